// File: rtl/uart_bus_master.sv
// uart_bus_master: drives a UART peripheral through a simple register bus.
// Runs the init sequence and moves TX bytes into the UART under a credit
// count read from reg 7. Polls reg 8 for the RX fill level, then reads reg 6
// to collect RX bytes. Reads reg 1 for errors and clears them by writing back.
// Ports:
//   mclk, reset                 clock, asynchronous active-high reset
//   cfg_init/cfg_ctrl/cfg_baud_16x, init_done   init request, config, status
//   tx_valid/tx_data/tx_ready   TX byte handshake (tx_ready = accepted)
//   rx_valid/rx_data/rx_ready   RX byte handshake (rx_valid held until taken)
//   err_pulse                   one-cycle error flags {fifo_full, parity, framing}
//   reg_*                       register bus master side (cs/wr/be/addr/wdata out,
//                               rdata/ack in)
module uart_bus_master #(
    parameter int unsigned POLL_CYCLES = 64
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        cfg_init,
    input  logic [5:0]  cfg_ctrl,
    input  logic [11:0] cfg_baud_16x,
    output logic        init_done,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [2:0]  err_pulse,
    output logic        reg_cs,
    output logic        reg_wr,
    output logic        reg_be,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  reg_rdata,
    input  logic        reg_ack
);

    localparam int unsigned TW = 10;
    localparam int unsigned CW = 5;
    localparam logic [TW-1:0] POLL_RELOAD = TW'(POLL_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT_R0 = 4'd1,
        INIT_R2 = 4'd2,
        INIT_R3 = 4'd3,
        RD_TXSP = 4'd4,
        WR_TX   = 4'd5,
        RD_RXDV = 4'd6,
        RD_RX   = 4'd7,
        RD_ERR  = 4'd8,
        CLR_ERR = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic            reg_cs_q, reg_cs_d, reg_wr_q, reg_wr_d, reg_be_q, reg_be_d;
    logic [3:0]      reg_addr_q, reg_addr_d;
    logic [7:0]      reg_wdata_q, reg_wdata_d;
    logic            tx_ready_q, tx_ready_d;
    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic [2:0]      err_pulse_q, err_pulse_d;
    logic            init_done_q, init_done_d;
    logic [CW-1:0]   tx_credit_q, tx_credit_d;
    logic [CW-1:0]   rx_avail_q, rx_avail_d;
    logic            init_pend_q, init_pend_d;
    logic [1:0]      init_stage_q, init_stage_d;
    logic            rd_err_pend_q, rd_err_pend_d;
    logic            clr_pend_q, clr_pend_d;
    logic [2:0]      err_val_q, err_val_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic xfer_done;
    logic launch;

    assign xfer_done = reg_cs_q & reg_ack;
    assign launch    = (state_q == IDLE) && (state_d != IDLE);

    // State register
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: IDLE arbitrates, every transfer state returns to IDLE on ack.
    // The cycle tx_ready is high still shows the byte just taken, so TX is masked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (init_pend_q)                          state_d = INIT_R0;
                else if (init_stage_q == 2'd1)            state_d = INIT_R2;
                else if (init_stage_q == 2'd2)            state_d = INIT_R3;
                else if (clr_pend_q)                      state_d = CLR_ERR;
                else if (init_done_q) begin
                    if (rd_err_pend_q)                    state_d = RD_ERR;
                    else if (rx_avail_q != '0 && !rx_valid_q) state_d = RD_RX;
                    else if (tx_valid && !tx_ready_q)
                        state_d = (tx_credit_q != '0) ? WR_TX : RD_TXSP;
                    else if (timer_q == '0)               state_d = RD_RXDV;
                end
            end
            default: if (xfer_done) state_d = IDLE;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        reg_cs_d      = reg_cs_q;
        reg_wr_d      = reg_wr_q;
        reg_be_d      = reg_be_q;
        reg_addr_d    = reg_addr_q;
        reg_wdata_d   = reg_wdata_q;
        tx_ready_d    = 1'b0;
        err_pulse_d   = '0;
        rx_valid_d    = rx_valid_q;
        rx_data_d     = rx_data_q;
        init_done_d   = init_done_q;
        tx_credit_d   = tx_credit_q;
        rx_avail_d    = rx_avail_q;
        init_pend_d   = init_pend_q;
        init_stage_d  = init_stage_q;
        rd_err_pend_d = rd_err_pend_q;
        clr_pend_d    = clr_pend_q;
        err_val_d     = err_val_q;
        timer_d       = timer_q;

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        // Poll timer counts only cycles spent idle after init
        if (state_q == IDLE && init_done_q && timer_q != '0) timer_d = timer_q - TW'(1);

        if (launch) begin
            reg_cs_d    = 1'b1;
            reg_be_d    = 1'b1;
            reg_wr_d    = 1'b0;
            reg_wdata_d = '0;
            case (state_d)
                INIT_R0: begin
                    reg_addr_d    = 4'd0;
                    reg_wr_d      = 1'b1;
                    reg_wdata_d   = {2'b00, cfg_ctrl};
                    init_pend_d   = 1'b0;
                    init_stage_d  = 2'd0;
                    init_done_d   = 1'b0;
                    tx_credit_d   = '0;
                    rx_avail_d    = '0;
                    rd_err_pend_d = 1'b0;
                end
                INIT_R2: begin
                    reg_addr_d  = 4'd2;
                    reg_wr_d    = 1'b1;
                    reg_wdata_d = cfg_baud_16x[7:0];
                end
                INIT_R3: begin
                    reg_addr_d  = 4'd3;
                    reg_wr_d    = 1'b1;
                    reg_wdata_d = {4'b0000, cfg_baud_16x[11:8]};
                end
                RD_TXSP: reg_addr_d = 4'd7;
                WR_TX: begin
                    reg_addr_d  = 4'd5;
                    reg_wr_d    = 1'b1;
                    reg_wdata_d = tx_data;
                end
                RD_RXDV: begin
                    reg_addr_d = 4'd8;
                    timer_d    = POLL_RELOAD;
                end
                RD_RX:   reg_addr_d = 4'd6;
                RD_ERR:  reg_addr_d = 4'd1;
                CLR_ERR: begin
                    reg_addr_d  = 4'd1;
                    reg_wr_d    = 1'b1;
                    reg_wdata_d = {5'b00000, err_val_q};
                    clr_pend_d  = 1'b0;
                end
                default: ;
            endcase
        end

        if (xfer_done) begin
            reg_cs_d = 1'b0;
            reg_be_d = 1'b0;
            reg_wr_d = 1'b0;
            case (state_q)
                INIT_R0: init_stage_d = 2'd1;
                INIT_R2: init_stage_d = 2'd2;
                INIT_R3: begin
                    init_stage_d = 2'd0;
                    init_done_d  = 1'b1;
                    timer_d      = POLL_RELOAD;
                end
                RD_TXSP: tx_credit_d = reg_rdata[4:0];
                WR_TX: begin
                    if (tx_credit_q != '0) tx_credit_d = tx_credit_q - CW'(1);
                    tx_ready_d = 1'b1;
                end
                RD_RXDV: begin
                    rx_avail_d    = reg_rdata[4:0];
                    rd_err_pend_d = 1'b1;
                end
                RD_RX: begin
                    rx_data_d  = reg_rdata;
                    rx_valid_d = 1'b1;
                    if (rx_avail_q != '0) rx_avail_d = rx_avail_q - CW'(1);
                end
                RD_ERR: begin
                    rd_err_pend_d = 1'b0;
                    timer_d       = POLL_RELOAD;
                    if (reg_rdata[2:0] != 3'b000) begin
                        err_pulse_d = reg_rdata[2:0];
                        err_val_d   = reg_rdata[2:0];
                        clr_pend_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // A request arriving mid-transfer waits here until IDLE picks it up
        if (cfg_init) init_pend_d = 1'b1;
    end

    // Datapath and registered outputs
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            reg_cs_q      <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_be_q      <= 1'b0;
            reg_addr_q    <= '0;
            reg_wdata_q   <= '0;
            tx_ready_q    <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            err_pulse_q   <= '0;
            init_done_q   <= 1'b0;
            tx_credit_q   <= '0;
            rx_avail_q    <= '0;
            init_pend_q   <= 1'b0;
            init_stage_q  <= 2'd0;
            rd_err_pend_q <= 1'b0;
            clr_pend_q    <= 1'b0;
            err_val_q     <= '0;
            timer_q       <= POLL_RELOAD;
        end else begin
            reg_cs_q      <= reg_cs_d;
            reg_wr_q      <= reg_wr_d;
            reg_be_q      <= reg_be_d;
            reg_addr_q    <= reg_addr_d;
            reg_wdata_q   <= reg_wdata_d;
            tx_ready_q    <= tx_ready_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            err_pulse_q   <= err_pulse_d;
            init_done_q   <= init_done_d;
            tx_credit_q   <= tx_credit_d;
            rx_avail_q    <= rx_avail_d;
            init_pend_q   <= init_pend_d;
            init_stage_q  <= init_stage_d;
            rd_err_pend_q <= rd_err_pend_d;
            clr_pend_q    <= clr_pend_d;
            err_val_q     <= err_val_d;
            timer_q       <= timer_d;
        end
    end

    assign reg_cs    = reg_cs_q;
    assign reg_wr    = reg_wr_q;
    assign reg_be    = reg_be_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign tx_ready  = tx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign err_pulse = err_pulse_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a behavioural register responder.
module tb_uart_bus_master;

    localparam int unsigned POLL = 16;

    logic        mclk;
    logic        reset;
    logic        cfg_init;
    logic [5:0]  cfg_ctrl;
    logic [11:0] cfg_baud_16x;
    logic        init_done;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [2:0]  err_pulse;
    logic        reg_cs;
    logic        reg_wr;
    logic        reg_be;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        reg_ack;

    typedef struct {
        logic [3:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         len;
    } xfer_t;

    xfer_t log_q[$];

    int checks;
    int failures;

    // Responder configuration, written only by the main sequence
    int         ack_delay;
    logic [7:0] rd7_val;
    logic [7:0] rx6_val;
    logic [7:0] rxdv_val;
    logic [7:0] err1_val;
    int         rxdv_req;
    int         err_req;

    // Written only by the responder / monitor
    int rxdv_srv = 0;
    int err_srv  = 0;
    int stab_err = 0;
    int be_err   = 0;
    int gap_err  = 0;
    int txr_cnt  = 0;
    int txr_wide = 0;

    uart_bus_master #(.POLL_CYCLES(POLL)) dut (
        .mclk         (mclk),
        .reset        (reset),
        .cfg_init     (cfg_init),
        .cfg_ctrl     (cfg_ctrl),
        .cfg_baud_16x (cfg_baud_16x),
        .init_done    (init_done),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .err_pulse    (err_pulse),
        .reg_cs       (reg_cs),
        .reg_wr       (reg_wr),
        .reg_be       (reg_be),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .reg_ack      (reg_ack)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // Register responder: acks ack_delay cycles after cs is first seen,
    // checks request stability while waiting, logs each completed transfer.
    initial begin : responder
        logic  busy;
        int    cnt;
        int    len;
        xfer_t cur;
        busy = 1'b0; cnt = 0; len = 0;
        cur.addr = '0; cur.wr = 1'b0; cur.wdata = '0; cur.rdata = '0; cur.len = 0;
        reg_ack = 1'b0;
        reg_rdata = '0;
        forever begin
            @(posedge mclk);
            #1;
            reg_ack = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (reg_cs !== 1'b1 || reg_be !== 1'b1 || reg_addr !== cur.addr ||
                        reg_wr !== cur.wr || reg_wdata !== cur.wdata)
                        stab_err++;
                end else if (reg_cs === 1'b1) begin
                    busy = 1'b1;
                    cnt = ack_delay;
                    len = 0;
                    cur.addr = reg_addr;
                    cur.wr = reg_wr;
                    cur.wdata = reg_wdata;
                    cur.rdata = '0;
                    if (reg_be !== 1'b1) be_err++;
                end
                if (busy) begin
                    len++;
                    if (cnt == 0) begin
                        if (!cur.wr) begin
                            case (cur.addr)
                                4'd7: cur.rdata = rd7_val;
                                4'd6: cur.rdata = rx6_val;
                                4'd8: if (rxdv_req != rxdv_srv) begin
                                    cur.rdata = rxdv_val;
                                    rxdv_srv = rxdv_req;
                                end
                                4'd1: if (err_req != err_srv) begin
                                    cur.rdata = err1_val;
                                    err_srv = err_req;
                                end
                                default: cur.rdata = '0;
                            endcase
                        end
                        cur.len = len;
                        reg_rdata = cur.rdata;
                        reg_ack = 1'b1;
                        log_q.push_back(cur);
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // cs must drop the cycle after an ack; tx_ready must be single-cycle
    initial begin : monitor
        logic prev_ack;
        logic prev_txr;
        prev_ack = 1'b0;
        prev_txr = 1'b0;
        forever begin
            @(negedge mclk);
            if (reset) begin
                prev_ack = 1'b0;
                prev_txr = 1'b0;
            end else begin
                if (prev_ack && reg_cs) gap_err++;
                prev_ack = reg_cs && reg_ack;
                if (tx_ready) begin
                    txr_cnt++;
                    if (prev_txr) txr_wide++;
                end
                prev_txr = tx_ready;
            end
        end
    end

    function automatic int count_reads(input int base, input logic [3:0] addr);
        int n;
        n = 0;
        for (int i = base; i < log_q.size(); i++)
            if (!log_q[i].wr && log_q[i].addr == addr) n++;
        return n;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        tx_valid = 1'b1;
        tx_data = b;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge mclk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge mclk);
        #1 tx_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_byte_%h: tx_ready got 0 expected 1 within bound", b);
        end
    endtask

    task automatic test_reset();
        int base;
        int t0;
        reset = 1'b1;
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        checks++; if (reg_cs !== 1'b0) begin failures++; $display("FAIL reset_cs: got %b expected 0", reg_cs); end
        checks++; if (reg_wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b expected 0", reg_wr); end
        checks++; if (reg_be !== 1'b0) begin failures++; $display("FAIL reset_be: got %b expected 0", reg_be); end
        checks++; if (reg_addr !== 4'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", reg_addr); end
        checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata: got %h expected 00", reg_wdata); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (err_pulse !== 3'b000) begin failures++; $display("FAIL reset_err_pulse: got %b expected 000", err_pulse); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        @(posedge mclk);
        #1 reset = 1'b0;
        base = log_q.size();
        t0 = txr_cnt;
        tx_valid = 1'b1;
        tx_data = 8'h99;
        repeat (3 * POLL) @(posedge mclk);
        #1 tx_valid = 1'b0;
        checks++;
        if (log_q.size() != base) begin
            failures++;
            $display("FAIL no_xfer_before_init: got %0d transfers expected 0", log_q.size() - base);
        end
        checks++;
        if (txr_cnt != t0) begin
            failures++;
            $display("FAIL no_tx_before_init: got %0d tx_ready expected 0", txr_cnt - t0);
        end
    endtask

    task automatic test_init();
        logic [12:0] exp [3];
        logic [12:0] got;
        int  base;
        logic ok;
        exp[0] = 13'h1003;
        exp[1] = 13'h1245;
        exp[2] = 13'h1301;
        base = log_q.size();
        cfg_ctrl = 6'h03;
        cfg_baud_16x = 12'h145;
        @(posedge mclk);
        #1 cfg_init = 1'b1;
        @(posedge mclk);
        #1 cfg_init = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge mclk);
            if (init_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL init_done: got 0 expected 1 within bound"); end
        checks++;
        if (log_q.size() - base != 3) begin
            failures++;
            $display("FAIL init_count: got %0d transfers expected 3", log_q.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (base + i >= log_q.size()) begin
                failures++;
                $display("FAIL init_xfer%0d: got none expected %h", i, exp[i]);
            end else begin
                got = {log_q[base+i].wr, log_q[base+i].addr, log_q[base+i].wdata};
                if (got !== exp[i]) begin
                    failures++;
                    $display("FAIL init_xfer%0d: got %h expected %h", i, got, exp[i]);
                end
            end
        end
    endtask

    task automatic test_tx_credit();
        logic [12:0] exp [5];
        logic [12:0] got;
        xfer_t f[$];
        int base;
        int t0;
        int w0;
        exp[0] = 13'h0700;
        exp[1] = 13'h1511;
        exp[2] = 13'h1522;
        exp[3] = 13'h0700;
        exp[4] = 13'h1533;
        rd7_val = 8'h02;
        base = log_q.size();
        t0 = txr_cnt;
        w0 = txr_wide;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (5) @(posedge mclk);
        for (int i = base; i < log_q.size(); i++)
            if (!(!log_q[i].wr && (log_q[i].addr == 4'd8 || log_q[i].addr == 4'd1)))
                f.push_back(log_q[i]);
        checks++;
        if (f.size() != 5) begin
            failures++;
            $display("FAIL tx_seq_len: got %0d transfers expected 5", f.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= f.size()) begin
                failures++;
                $display("FAIL tx_seq%0d: got none expected %h", i, exp[i]);
            end else begin
                got = {f[i].wr, f[i].addr, f[i].wdata};
                if (got !== exp[i]) begin
                    failures++;
                    $display("FAIL tx_seq%0d: got %h expected %h", i, got, exp[i]);
                end
            end
        end
        checks++;
        if (txr_cnt - t0 != 3) begin
            failures++;
            $display("FAIL tx_ready_count: got %0d expected 3", txr_cnt - t0);
        end
        checks++;
        if (txr_wide != w0) begin
            failures++;
            $display("FAIL tx_ready_width: got %0d multi-cycle pulses expected 0", txr_wide - w0);
        end
    endtask

    task automatic test_rx();
        int base;
        logic ok;
        int n6;
        rx6_val = 8'hA5;
        rxdv_val = 8'h01;
        rxdv_req = rxdv_req + 1;
        base = log_q.size();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge mclk);
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL rx_valid: got 0 expected 1 within bound"); end
        checks++;
        if (rx_data !== 8'hA5) begin failures++; $display("FAIL rx_data: got %h expected a5", rx_data); end
        n6 = count_reads(base, 4'd6);
        checks++;
        if (n6 != 1) begin failures++; $display("FAIL rx_reads: got %0d expected 1", n6); end
        for (int i = 0; i < 10; i++) begin
            @(negedge mclk);
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
                failures++;
                $display("FAIL rx_hold%0d: got valid=%b data=%h expected valid=1 data=a5", i, rx_valid, rx_data);
            end
        end
        n6 = count_reads(base, 4'd6);
        checks++;
        if (n6 != 1) begin failures++; $display("FAIL rx_no_extra_reads: got %0d expected 1", n6); end
        @(posedge mclk);
        #1 rx_ready = 1'b1;
        @(posedge mclk);
        #1 rx_ready = 1'b0;
        @(negedge mclk);
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL rx_consume: got %b expected 0", rx_valid); end
    endtask

    task automatic test_err();
        int base;
        int idx;
        logic ok;
        logic [12:0] got;
        err1_val = 8'h04;
        err_req = err_req + 1;
        base = log_q.size();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge mclk);
            if (err_pulse != 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL err_pulse_seen: got 000 expected 100 within bound"); end
        checks++;
        if (err_pulse !== 3'b100) begin failures++; $display("FAIL err_pulse_value: got %b expected 100", err_pulse); end
        @(negedge mclk);
        checks++;
        if (err_pulse !== 3'b000) begin failures++; $display("FAIL err_pulse_width: got %b expected 000", err_pulse); end
        repeat (10) @(posedge mclk);
        idx = -1;
        for (int i = base; i < log_q.size(); i++)
            if (!log_q[i].wr && log_q[i].addr == 4'd1 && log_q[i].rdata == 8'h04) begin
                idx = i;
                break;
            end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL err_clear: got no error read expected read of 04");
        end else if (idx + 1 >= log_q.size()) begin
            failures++;
            $display("FAIL err_clear: got no follow-up transfer expected 1104");
        end else begin
            got = {log_q[idx+1].wr, log_q[idx+1].addr, log_q[idx+1].wdata};
            if (got !== 13'h1104) begin
                failures++;
                $display("FAIL err_clear: got %h expected 1104", got);
            end
        end
    endtask

    task automatic test_handshake();
        int base;
        int s0;
        int g0;
        int b0;
        int t0;
        int idx;
        ack_delay = 5;
        s0 = stab_err;
        g0 = gap_err;
        b0 = be_err;
        t0 = txr_cnt;
        base = log_q.size();
        send_byte(8'h5A);
        repeat (20) @(posedge mclk);
        idx = -1;
        for (int i = base; i < log_q.size(); i++)
            if (log_q[i].wr && log_q[i].addr == 4'd5) begin
                idx = i;
                break;
            end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL hs_write: got no write to 5 expected data 5a");
        end else if (log_q[idx].wdata !== 8'h5A || log_q[idx].len != 6) begin
            failures++;
            $display("FAIL hs_write: got data=%h cs_cycles=%0d expected data=5a cs_cycles=6",
                     log_q[idx].wdata, log_q[idx].len);
        end
        checks++;
        if (stab_err != s0) begin failures++; $display("FAIL hs_stable: got %0d unstable cycles expected 0", stab_err - s0); end
        checks++;
        if (gap_err != g0) begin failures++; $display("FAIL hs_cs_gap: got %0d missing gaps expected 0", gap_err - g0); end
        checks++;
        if (be_err != b0) begin failures++; $display("FAIL hs_be: got %0d transfers with be=0 expected 0", be_err - b0); end
        checks++;
        if (txr_cnt - t0 != 1) begin failures++; $display("FAIL hs_tx_ready: got %0d expected 1", txr_cnt - t0); end
    endtask

    task automatic test_reset_mid_tx();
        int base;
        int t0;
        logic ok;
        ack_delay = 8;
        rd7_val = 8'h02;
        t0 = txr_cnt;
        tx_valid = 1'b1;
        tx_data = 8'h77;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge mclk);
            if (reg_cs && reg_wr && reg_addr == 4'd5) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL rst_wr_tx_seen: got no WR_TX expected one within bound"); end
        @(negedge mclk);
        reset = 1'b1;
        #1;
        checks++;
        if (reg_cs !== 1'b0) begin failures++; $display("FAIL rst_async_cs: got %b expected 0", reg_cs); end
        checks++;
        if (init_done !== 1'b0) begin failures++; $display("FAIL rst_async_init_done: got %b expected 0", init_done); end
        checks++;
        if (tx_ready !== 1'b0) begin failures++; $display("FAIL rst_async_tx_ready: got %b expected 0", tx_ready); end
        repeat (2) @(posedge mclk);
        #1 reset = 1'b0;
        base = log_q.size();
        repeat (40) @(posedge mclk);
        #1 tx_valid = 1'b0;
        checks++;
        if (log_q.size() != base) begin
            failures++;
            $display("FAIL rst_no_retry: got %0d transfers expected 0", log_q.size() - base);
        end
        checks++;
        if (txr_cnt != t0) begin failures++; $display("FAIL rst_no_tx_ready: got %0d expected 0", txr_cnt - t0); end
        checks++;
        if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        cfg_init = 1'b0;
        cfg_ctrl = '0;
        cfg_baud_16x = '0;
        tx_valid = 1'b0;
        tx_data = '0;
        rx_ready = 1'b0;
        ack_delay = 0;
        rd7_val = '0;
        rx6_val = '0;
        rxdv_val = '0;
        err1_val = '0;
        rxdv_req = 0;
        err_req = 0;

        test_reset();
        test_init();
        test_tx_credit();
        test_rx();
        test_err();
        test_handshake();
        test_reset_mid_tx();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
